enemy_sprite_scheduler: RTL
===========================

// Module: enemy_sprite_scheduler
// PURPOSE
//  Shares one 40x66 4-bpp enemy sprite ROM (with its palette) among N_ENEMY on-screen enemies.
//  Runs a lifecycle FSM and animation counter per enemy slot.
//  Resolves which slot owns the current pixel and generates the ROM address with a frame offset.
//  Emits sprite_hit/hit_id aligned with rom_q; sits between game logic and the ROM/palette pair.
// PARAMETERS
//  N_ENEMY     4   enemy slots (1..4); hit_id width fixed at 2
//  ANIM_DIV    8   frame_start pulses per walk-frame toggle (>=1)
//  DIE_FRAMES  32  frame_start pulses spent in DYING (>=2)
// PORTS
//  vga_clk      in   1            pixel clock; the only clock
//  reset_n      in   1            asynchronous, active-low reset
//  frame_start  in   1            1-cycle pulse at start of vertical blank
//  DrawX        in   10           current pixel column
//  DrawY        in   10           current pixel row
//  spawn        in   N_ENEMY      per-slot spawn request, 1-cycle pulse
//  kill         in   N_ENEMY      per-slot kill request, 1-cycle pulse
//  enemy_x      in   10*N_ENEMY   slot i top-left X at [10i+9:10i]
//  enemy_y      in   10*N_ENEMY   slot i top-left Y at [10i+9:10i]
//  rom_address  out  13           sprite ROM address (ROM has 1-cycle read latency)
//  sprite_hit   out  1            rom_q this cycle belongs to a visible enemy
//  hit_id       out  2            slot index owning rom_q; valid when sprite_hit=1
//  alive        out  N_ENEMY      slot state is ALIVE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all slots HIDDEN; anim/die counters 0; latched positions 0
//   - rom_address=0, sprite_hit=0, hit_id=0, alive=0
//  Slot FSM (requests apply on the cycle they are sampled):
//   - HIDDEN --spawn--> ALIVE; walk frame=0, anim counter=0
//   - ALIVE --kill--> DYING; die counter=0
//   - DYING: die counter increments on frame_start;
//     on the frame_start where counter==DIE_FRAMES-1 -> HIDDEN
//   - Ignored: spawn in ALIVE/DYING; kill in HIDDEN/DYING
//   - spawn&kill same cycle: HIDDEN->ALIVE, ALIVE->DYING
//  Animation (ALIVE only):
//   - anim counter counts frame_start pulses
//   - at ANIM_DIV-1 it wraps to 0 and walk frame toggles 0<->1
//   - DYING uses frame 2
//   - DYING slot visible only while die counter bit0==0 (blink)
//  Position latching:
//   - enemy_x/enemy_y latched per slot only on frame_start (no mid-frame tearing)
//   - on spawn, that slot's position is also latched the same cycle
//  Pixel resolution (comb):
//   - dx=DrawX-x, dy=DrawY-y, 10-bit unsigned
//   - inside = visible && dx<40 && dy<66; negative offsets wrap large -> outside
//   - lowest-index inside slot wins
//  Address:
//   - frame*2640 + dy*40 + dx; max 7919, fits 13 bits
//   - no inside slot -> address 0
//  Pipeline / latency:
//   - rom_address registered: 1 cycle after DrawX/DrawY
//   - sprite_hit/hit_id registered twice: 2 cycles after DrawX/DrawY, aligned with rom_q
//   - palette index 0 is transparency; handled by the compositor, not here
//  Reset mid-frame: pipeline flushes to sprite_hit=0 immediately (async).
// STRUCTURE
//  - Package enemy_sprite_pkg:
//    SPRITE_W=40, SPRITE_H=66, FRAME_WORDS=2640, DIE_FRAME_IDX=2
//    typedef enum logic[1:0] {HIDDEN, ALIVE, DYING} slot_state_t
//  - Sub-module enemy_slot_fsm, one instance per slot: FSM, anim/die counters,
//    position latch, visible flag, current frame index
//  - Top: generate loop of slots, priority pick, address multiply-add, 2-stage pipeline
// TESTING
//  1. Reset mid-run, reset_n=0 -> all outputs 0 same cycle; after release alive=0, sprite_hit=0 on all pixels.
//  2. spawn[0], pos (100,50); DrawX=105, DrawY=52 -> rom_address=85 at +1 cycle; sprite_hit=1, hit_id=0 at +2.
//  3. Slots 0 and 1 spawned at (100,50) and (120,50); pixel (125,60) -> hit_id=0; pixel (145,60) -> hit_id=1.
//  4. ANIM_DIV=8, slot 0 alive; after 8 frame_start, pixel (100,50) -> rom_address=2640; after 16 -> 0.
//  5. kill[0] -> alive[0]=0; pixel (100,50) -> address 5280.
//     Hit on die count 0, none on die count 1.
//     After 32 frame_start: HIDDEN, sprite_hit=0.
//  6. Boundaries and edges:
//     - pos (600,450): pixel (639,479) hit, address 39+29*40=1199; pixel (599,450) no hit
//     - spawn&kill same cycle on HIDDEN slot -> ALIVE
//     - kill on HIDDEN slot -> no change

Source files
------------

// File: rtl/enemy_sprite_pkg.sv
// Shared sprite geometry, slot state encoding and the ROM address helper
// for the enemy sprite scheduler.
package enemy_sprite_pkg;

    localparam int SPRITE_W      = 40;
    localparam int SPRITE_H      = 66;
    localparam int FRAME_WORDS   = 2640;
    localparam int DIE_FRAME_IDX = 2;

    typedef enum logic [1:0] {HIDDEN, ALIVE, DYING} slot_state_t;

    // frame*2640 + dy*40 + dx stays below 7920, so 13-bit arithmetic cannot overflow
    function automatic logic [12:0] sprite_addr(input logic [1:0] frame,
                                                input logic [9:0] dx,
                                                input logic [9:0] dy);
        logic [12:0] base;
        base = 13'(frame) * 13'(FRAME_WORDS);
        return base + 13'(dy) * 13'(SPRITE_W) + 13'(dx);
    endfunction

endpackage

// File: rtl/enemy_slot_fsm.sv
// One enemy slot: lifecycle FSM, walk/die counters, frame-latched position
// and the visible flag / frame index consumed by the pixel resolver.
//
//   state  | meaning
//   HIDDEN | slot unused, never drawn
//   ALIVE  | walking, frame toggles every ANIM_DIV frame_start pulses
//   DYING  | death frame, blinks on die counter bit0, leaves after DIE_FRAMES
module enemy_slot_fsm
    import enemy_sprite_pkg::*;
#(
    parameter int ANIM_DIV   = 8,
    parameter int DIE_FRAMES = 32
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_start_i,
    input  logic       spawn_i,
    input  logic       kill_i,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       visible_o,
    output logic       alive_o,
    output logic [1:0] frame_o
);

    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int DW = $clog2(DIE_FRAMES);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
    localparam logic [DW-1:0] DIE_LAST  = DW'(DIE_FRAMES - 1);

    slot_state_t   state_q, state_d;
    logic [AW-1:0] anim_q, anim_d;
    logic          walk_q, walk_d;
    logic [DW-1:0] die_q, die_d;
    logic [9:0]    x_q, y_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HIDDEN;
            anim_q  <= '0;
            walk_q  <= 1'b0;
            die_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            anim_q  <= anim_d;
            walk_q  <= walk_d;
            die_q   <= die_d;
            // a freshly spawned slot must not wait a whole frame for its position
            if (frame_start_i || (state_q == HIDDEN && spawn_i)) begin
                x_q <= x_i;
                y_q <= y_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        anim_d  = anim_q;
        walk_d  = walk_q;
        die_d   = die_q;
        case (state_q)
            HIDDEN: begin
                if (spawn_i) begin
                    state_d = ALIVE;
                    anim_d  = '0;
                    walk_d  = 1'b0;
                end
            end
            ALIVE: begin
                if (kill_i) begin
                    state_d = DYING;
                    die_d   = '0;
                end else if (frame_start_i) begin
                    if (anim_q == ANIM_LAST) begin
                        anim_d = '0;
                        walk_d = ~walk_q;
                    end else begin
                        anim_d = anim_q + AW'(1);
                    end
                end
            end
            DYING: begin
                if (frame_start_i) begin
                    if (die_q == DIE_LAST) begin
                        state_d = HIDDEN;
                        die_d   = '0;
                    end else begin
                        die_d = die_q + DW'(1);
                    end
                end
            end
            default: state_d = HIDDEN;
        endcase
    end

    always_comb begin
        alive_o   = (state_q == ALIVE);
        visible_o = (state_q == ALIVE) || (state_q == DYING && !die_q[0]);
        frame_o   = (state_q == DYING) ? 2'(DIE_FRAME_IDX) : {1'b0, walk_q};
        x_o       = x_q;
        y_o       = y_q;
    end

endmodule

// File: rtl/enemy_sprite_scheduler.sv
// Shares one enemy sprite ROM among N_ENEMY slots: per-slot lifecycle, lowest-index
// pixel ownership, ROM address generation and hit flags aligned with rom_q.
module enemy_sprite_scheduler
    import enemy_sprite_pkg::*;
#(
    parameter int N_ENEMY    = 4,
    parameter int ANIM_DIV   = 8,
    parameter int DIE_FRAMES = 32
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [N_ENEMY-1:0]   spawn,
    input  logic [N_ENEMY-1:0]   kill,
    input  logic [10*N_ENEMY-1:0] enemy_x,
    input  logic [10*N_ENEMY-1:0] enemy_y,
    output logic [12:0]          rom_address,
    output logic                 sprite_hit,
    output logic [1:0]           hit_id,
    output logic [N_ENEMY-1:0]   alive
);

    logic [9:0]         slot_x  [N_ENEMY];
    logic [9:0]         slot_y  [N_ENEMY];
    logic [9:0]         slot_dx [N_ENEMY];
    logic [9:0]         slot_dy [N_ENEMY];
    logic [1:0]         slot_frame [N_ENEMY];
    logic [N_ENEMY-1:0] slot_vis;
    logic [N_ENEMY-1:0] slot_in;

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_slot
        enemy_slot_fsm #(
            .ANIM_DIV   (ANIM_DIV),
            .DIE_FRAMES (DIE_FRAMES)
        ) u_slot (
            .vga_clk       (vga_clk),
            .reset_n       (reset_n),
            .frame_start_i (frame_start),
            .spawn_i       (spawn[g]),
            .kill_i        (kill[g]),
            .x_i           (enemy_x[10*g +: 10]),
            .y_i           (enemy_y[10*g +: 10]),
            .x_o           (slot_x[g]),
            .y_o           (slot_y[g]),
            .visible_o     (slot_vis[g]),
            .alive_o       (alive[g]),
            .frame_o       (slot_frame[g])
        );

        // unsigned wrap turns pixels left of / above the sprite into huge offsets
        assign slot_dx[g] = DrawX - slot_x[g];
        assign slot_dy[g] = DrawY - slot_y[g];
        assign slot_in[g] = slot_vis[g] && (slot_dx[g] < 10'(SPRITE_W))
                                        && (slot_dy[g] < 10'(SPRITE_H));
    end

    logic        hit_d;
    logic [1:0]  id_d;
    logic [9:0]  dx_sel, dy_sel;
    logic [1:0]  frame_sel;
    logic [12:0] addr_d;

    always_comb begin
        hit_d     = 1'b0;
        id_d      = 2'd0;
        dx_sel    = '0;
        dy_sel    = '0;
        frame_sel = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (slot_in[i]) begin
                hit_d     = 1'b1;
                id_d      = 2'(i);
                dx_sel    = slot_dx[i];
                dy_sel    = slot_dy[i];
                frame_sel = slot_frame[i];
            end
        end
        addr_d = hit_d ? sprite_addr(frame_sel, dx_sel, dy_sel) : 13'd0;
    end

    logic [12:0] addr_q;
    logic        hit1_q, hit2_q;
    logic [1:0]  id1_q, id2_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            hit1_q <= 1'b0;
            id1_q  <= '0;
            hit2_q <= 1'b0;
            id2_q  <= '0;
        end else begin
            addr_q <= addr_d;
            hit1_q <= hit_d;
            id1_q  <= id_d;
            hit2_q <= hit1_q;
            id2_q  <= id1_q;
        end
    end

    assign rom_address = addr_q;
    assign sprite_hit  = hit2_q;
    assign hit_id      = id2_q;

endmodule
